// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: rebuilds BCD digits from a scanned active-low 7-seg bus.
// Ports: clk, rst_n | SEG, AN in | DIGIT_VAL/DP/ERR, FRAME_DONE, FRAME_CNT out.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  SEG,
  input  logic [7:0]  AN,
  output logic [31:0] DIGIT_VAL,
  output logic [7:0]  DIGIT_DP,
  output logic [7:0]  DIGIT_ERR,
  output logic        FRAME_DONE,
  output logic [7:0]  FRAME_CNT
);

  localparam logic [7:0] SMAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] SM1  = 8'(STABLE_CYCLES - 1);

  logic [15:0] s1, s2, prev;
  logic [7:0]  cnt;
  logic [7:0]  mask;
  logic        eq;
  logic [7:0]  sel;
  logic        an_ok;
  logic        cap;
  logic [2:0]  idx;
  logic [3:0]  dec;
  logic        dec_ok;
  logic [7:0]  bit_i;
  logic [7:0]  mask_n;

  assign eq    = (s2 == prev);
  assign sel   = ~s2[15:8];
  // exactly one digit selected
  assign an_ok = (sel != 8'd0) &&
                 ((sel & (sel - 8'd1)) == 8'd0);
  assign cap   = eq && (cnt == SM1) && an_ok;

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) idx = 3'(i);
    end
  end

  always_comb begin
    dec    = 4'd0;
    dec_ok = 1'b1;
    case (s2[6:0])
      7'h40:   dec = 4'd0;
      7'h79:   dec = 4'd1;
      7'h24:   dec = 4'd2;
      7'h30:   dec = 4'd3;
      7'h19:   dec = 4'd4;
      7'h12:   dec = 4'd5;
      7'h02:   dec = 4'd6;
      7'h78:   dec = 4'd7;
      7'h00:   dec = 4'd8;
      7'h18:   dec = 4'd9;
      7'h7F:   dec = 4'hF;
      default: dec_ok = 1'b0;
    endcase
  end

  assign bit_i  = 8'd1 << idx;
  assign mask_n = mask | bit_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 16'hFFFF;
      s2   <= 16'hFFFF;
      prev <= 16'hFFFF;
      cnt  <= 8'd0;
    end else begin
      s1   <= {AN, SEG};
      s2   <= s1;
      prev <= s2;
      // saturating so the strobe fires once per stable period
      if (!eq)            cnt <= 8'd0;
      else if (cnt < SMAX) cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DIGIT_VAL  <= 32'd0;
      DIGIT_DP   <= 8'd0;
      DIGIT_ERR  <= 8'd0;
      FRAME_DONE <= 1'b0;
      FRAME_CNT  <= 8'd0;
      mask       <= 8'd0;
    end else begin
      FRAME_DONE <= 1'b0;
      if (cap) begin
        if (dec_ok) DIGIT_VAL[idx*4 +: 4] <= dec;
        DIGIT_ERR[idx] <= ~dec_ok;
        DIGIT_DP[idx]  <= ~s2[7];
        if (mask_n == 8'hFF) begin
          mask       <= 8'd0;
          FRAME_DONE <= 1'b1;
          FRAME_CNT  <= FRAME_CNT + 8'd1;
        end else begin
          mask <= mask_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: vector table, corner sequences and random scan
// checked against a run-length reference model.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  SEG = 8'hFF;
  logic [7:0]  AN = 8'hFF;
  logic [31:0] DIGIT_VAL;
  logic [7:0]  DIGIT_DP;
  logic [7:0]  DIGIT_ERR;
  logic        FRAME_DONE;
  logic [7:0]  FRAME_CNT;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .SEG(SEG), .AN(AN),
    .DIGIT_VAL(DIGIT_VAL), .DIGIT_DP(DIGIT_DP),
    .DIGIT_ERR(DIGIT_ERR), .FRAME_DONE(FRAME_DONE),
    .FRAME_CNT(FRAME_CNT)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int nprint = 0;
  int ndone = 0;

  // ---------------- reference model ----------------
  logic [6:0] pat [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h18, 7'h7F};
  logic [3:0] pval [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                            4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'hF};

  logic [31:0] m_val;
  logic [7:0]  m_dp, m_err, m_cnt;
  logic        m_done;
  bit   [7:0]  m_seen;
  logic [15:0] last;
  int          run;
  logic        v1, v2;
  logic [15:0] p1, p2;

  function automatic int one_low(input logic [7:0] an);
    int n = 0, k = -1;
    for (int i = 0; i < 8; i++) if (!an[i]) begin n++; k = i; end
    return (n == 1) ? k : -1;
  endfunction

  task automatic model_apply(input logic [15:0] smp);
    int d, hit;
    d = one_low(smp[15:8]);
    hit = -1;
    for (int j = 0; j < 11; j++) if (pat[j] == smp[6:0]) hit = j;
    if (hit >= 0) m_val[d*4 +: 4] = pval[hit];
    m_err[d] = (hit < 0);
    m_dp[d]  = ~smp[7];
    m_seen[d] = 1'b1;
    if (m_seen == 8'hFF) begin
      m_seen = 8'd0;
      m_done = 1'b1;
      m_cnt  = m_cnt + 8'd1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = 0; m_dp = 0; m_err = 0; m_cnt = 0;
      m_done = 0; m_seen = 0;
      last = 16'hFFFF; run = 2;
      v1 = 0; v2 = 0; p1 = 0; p2 = 0;
    end else begin
      logic [15:0] cur;
      cur = {AN, SEG};
      m_done = 1'b0;
      if (v2) model_apply(p2);
      v2 = v1; p2 = p1;
      if (cur == last) run = (run < 1000) ? run + 1 : run;
      else run = 1;
      last = cur;
      // a run of S+1 equal samples is captured two edges later
      v1 = (run == S + 1) && (one_low(cur[15:8]) >= 0);
      p1 = cur;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      vectors++;
      if (FRAME_DONE) ndone++;
      if ({DIGIT_VAL, DIGIT_DP, DIGIT_ERR, FRAME_DONE, FRAME_CNT} !==
          {m_val, m_dp, m_err, m_done, m_cnt}) begin
        miscompares++;
        if (nprint < 20)
          $display("FAIL model t=%0t got val=%h dp=%h err=%h done=%b cnt=%0d want val=%h dp=%h err=%h done=%b cnt=%0d",
                   $time, DIGIT_VAL, DIGIT_DP, DIGIT_ERR, FRAME_DONE,
                   FRAME_CNT, m_val, m_dp, m_err, m_done, m_cnt);
        nprint++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [7:0] seg,
                       input int n);
    AN = an; SEG = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    AN = 8'($urandom); SEG = 8'($urandom);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic scan(input int hold);
    for (int i = 0; i < 8; i++)
      drive(~(8'd1 << i), {1'b1, pat[(i * 3) % 10]}, hold);
  endtask

  typedef struct {
    logic [7:0] an;
    logic [7:0] seg;
    int         hold;
    int         dig;
    logic [3:0] nib;
    logic       err;
    logic       dp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int d0;
    logic [31:0] snap_v;
    logic [7:0]  snap_c;

    tbl[0]  = '{8'hFE, 8'hB0, 20, 0, 4'd3, 1'b0, 1'b0};
    tbl[1]  = '{8'hFD, 8'hF9, 20, 1, 4'd1, 1'b0, 1'b0};
    tbl[2]  = '{8'hFB, 8'h99, 20, 2, 4'd4, 1'b0, 1'b0};
    tbl[3]  = '{8'hF7, 8'hF9, 20, 3, 4'd1, 1'b0, 1'b0};
    tbl[4]  = '{8'hEF, 8'h92, 20, 4, 4'd5, 1'b0, 1'b0};
    tbl[5]  = '{8'hDF, 8'h98, 20, 5, 4'd9, 1'b0, 1'b0};
    tbl[6]  = '{8'hBF, 8'hA4, 20, 6, 4'd2, 1'b0, 1'b0};
    tbl[7]  = '{8'h7F, 8'h82, 20, 7, 4'd6, 1'b0, 1'b0};
    tbl[8]  = '{8'hDF, 8'h55, 20, 5, 4'd9, 1'b1, 1'b1};
    tbl[9]  = '{8'hDF, 8'h7F, 20, 5, 4'hF, 1'b0, 1'b1};
    tbl[10] = '{8'hDF, 8'h00, 20, 5, 4'd8, 1'b0, 1'b1};

    @(negedge clk);
    do_reset(5);
    chk("rst_val", DIGIT_VAL, 32'd0);
    chk("rst_misc", {23'd0, DIGIT_DP, DIGIT_ERR, FRAME_DONE},
        32'd0);
    chk("rst_cnt", {24'd0, FRAME_CNT}, 32'd0);
    drive(8'hFE, 8'hF9, 6);
    chk("lat_before", DIGIT_VAL, 32'd0);
    drive(8'hFE, 8'hF9, 1);
    chk("lat_after", DIGIT_VAL, 32'd1);
    drive(8'hFF, 8'hFF, 10);

    do_reset(2);
    d0 = ndone;
    for (int r = 0; r < 8; r++) begin
      drive(tbl[r].an, tbl[r].seg, tbl[r].hold);
      chk($sformatf("row%0d_nib", r),
          {28'd0, DIGIT_VAL[tbl[r].dig*4 +: 4]}, {28'd0, tbl[r].nib});
    end
    chk("scan_val", DIGIT_VAL, 32'h62951413);
    chk("scan_cnt", {24'd0, FRAME_CNT}, 32'd1);
    chk("scan_pulses", 32'(ndone - d0), 32'd1);
    for (int r = 8; r < 11; r++) begin
      drive(tbl[r].an, tbl[r].seg, tbl[r].hold);
      chk($sformatf("row%0d", r),
          {26'd0, DIGIT_VAL[tbl[r].dig*4 +: 4], DIGIT_ERR[tbl[r].dig],
           DIGIT_DP[tbl[r].dig]},
          {26'd0, tbl[r].nib, tbl[r].err, tbl[r].dp});
    end
    chk("err_val", DIGIT_VAL, 32'h62851413);

    drive(8'hFB, 8'hA4, 20);
    drive(8'hFB, 8'hB0, 3);
    drive(8'hFB, 8'hA4, 3);
    chk("glitch_mid", {28'd0, DIGIT_VAL[11:8]}, 32'd2);
    drive(8'hFB, 8'hA4, 20);
    chk("glitch_end", {28'd0, DIGIT_VAL[11:8]}, 32'd2);

    do_reset(2);
    for (int i = 0; i < 4; i++) drive(~(8'd1 << i), 8'hC0, 10);
    snap_v = DIGIT_VAL; snap_c = FRAME_CNT;
    drive(8'hFF, 8'h80, 50);
    drive(8'hFC, 8'h80, 50);
    chk("inv_val", DIGIT_VAL, snap_v);
    chk("inv_cnt", {24'd0, FRAME_CNT}, {24'd0, snap_c});
    for (int i = 4; i < 8; i++) drive(~(8'd1 << i), 8'hC0, 10);
    chk("inv_mask", {24'd0, FRAME_CNT}, 32'd1);

    do_reset(2);
    d0 = ndone;
    for (int f = 0; f < 256; f++) scan(7);
    drive(8'hFF, 8'hFF, 4);
    chk("wrap_cnt", {24'd0, FRAME_CNT}, 32'd0);
    chk("wrap_pulses", 32'(ndone - d0), 32'd256);

    for (int i = 0; i < 4; i++) drive(~(8'd1 << i), 8'hC0, 10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    d0 = ndone;
    for (int i = 0; i < 7; i++) drive(~(8'd1 << i), 8'h99, 10);
    chk("mid_none", 32'(ndone - d0), 32'd0);
    drive(8'h7F, 8'h99, 10);
    chk("mid_one", 32'(ndone - d0), 32'd1);
    chk("mid_cnt", {24'd0, FRAME_CNT}, 32'd1);

    for (int k = 0; k < 500; k++) begin
      logic [7:0] an, seg;
      an = ($urandom_range(0, 9) < 8) ? ~(8'd1 << $urandom_range(0, 7))
                                       : 8'($urandom);
      seg = ($urandom_range(0, 9) < 7)
          ? {1'($urandom), pat[$urandom_range(0, 10)]} : 8'($urandom);
      drive(an, seg, $urandom_range(1, 12));
    end
    drive(8'hFF, 8'hFF, 5);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
